// File: rtl/pipe_scoreboard_if.sv
// Issue/hazard bundle between the ID stage and the pipeline scoreboard.
// The master side issues instructions; the slave side returns stall and forwarding info.
interface pipe_scoreboard_if #(
  parameter int AW = 5,
  parameter int SW = 3
);
  logic          issue_valid;
  logic [AW-1:0] issue_rs;
  logic [AW-1:0] issue_rt;
  logic          issue_use_rs;
  logic          issue_use_rt;
  logic [AW-1:0] issue_rd;
  logic          issue_we;
  logic          issue_is_load;
  logic          flush;
  logic          hold_ext;
  logic          stall;
  logic [SW-1:0] fwd_a;
  logic [SW-1:0] fwd_b;
  logic [SW-1:0] inflight_cnt;
  logic          busy;

  modport master (
    output issue_valid, issue_rs, issue_rt, issue_use_rs, issue_use_rt,
           issue_rd, issue_we, issue_is_load, flush, hold_ext,
    input  stall, fwd_a, fwd_b, inflight_cnt, busy
  );

  modport slave (
    input  issue_valid, issue_rs, issue_rt, issue_use_rs, issue_use_rt,
           issue_rd, issue_we, issue_is_load, flush, hold_ext,
    output stall, fwd_a, fwd_b, inflight_cnt, busy
  );
endinterface

// File: rtl/pipe_scoreboard.sv
// In-order pipeline scoreboard: tracks destination registers per stage, detects
// load-use hazards and registers the forwarding source stage for each operand.
module pipe_scoreboard #(
  parameter int DEPTH      = 4,
  parameter int AW         = 5,
  parameter int LOAD_STAGE = 2
) (
  input logic            clock,
  input logic            reset,
  pipe_scoreboard_if.slave sb
);
  localparam int SW = $clog2(DEPTH + 1);

  // Bit index i holds stage i+1 (index 0 = EX).
  logic [DEPTH-1:0]         valid_q, valid_d;
  logic [DEPTH-1:0]         we_q, we_d;
  logic [DEPTH-1:0]         load_q, load_d;
  logic [DEPTH-1:0][AW-1:0] rd_q, rd_d;
  logic [SW-1:0]            fwd_a_q, fwd_a_d;
  logic [SW-1:0]            fwd_b_q, fwd_b_d;
  logic [SW-1:0]            cnt_q, cnt_d;

  logic [SW-1:0] prod_a_s, prod_b_s;
  logic          load_a_s, load_b_s;
  logic          hazard_s, accept_s, wr_s;

  // Returns {is_load, stage} of the youngest writer of src; stage 0 means none.
  function automatic logic [SW:0] find_producer(
    input logic [AW-1:0]            src,
    input logic [DEPTH-1:0]         vld,
    input logic [DEPTH-1:0]         we,
    input logic [DEPTH-1:0]         ld,
    input logic [DEPTH-1:0][AW-1:0] rd
  );
    logic [SW:0] res;
    res = '0;
    for (int k = DEPTH; k >= 1; k--) begin
      if ((src != {AW{1'b0}}) && vld[k-1] && we[k-1] && (rd[k-1] == src)) begin
        res = {ld[k-1], SW'(k)};
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

  function automatic logic [SW-1:0] count_ones(input logic [DEPTH-1:0] v);
    logic [SW-1:0] c;
    c = '0;
    for (int i = 0; i < DEPTH; i++) begin
      c = c + {{(SW-1){1'b0}}, v[i]};
    end
    return c;
  endfunction

  // Producer lookup and hazard detection for the instruction sitting in ID.
  always_comb begin
    {load_a_s, prod_a_s} = find_producer(sb.issue_rs, valid_q, we_q, load_q, rd_q);
    {load_b_s, prod_b_s} = find_producer(sb.issue_rt, valid_q, we_q, load_q, rd_q);
    hazard_s = (sb.issue_use_rs & load_a_s & (prod_a_s < SW'(LOAD_STAGE))) |
               (sb.issue_use_rt & load_b_s & (prod_b_s < SW'(LOAD_STAGE)));
    accept_s = sb.issue_valid & ~hazard_s & ~sb.flush;
    wr_s     = accept_s & sb.issue_we & (sb.issue_rd != {AW{1'b0}});
  end

  // Next-state: freeze on hold_ext, otherwise shift and insert issue or bubble.
  always_comb begin
    valid_d = valid_q;
    we_d    = we_q;
    load_d  = load_q;
    rd_d    = rd_q;
    fwd_a_d = fwd_a_q;
    fwd_b_d = fwd_b_q;
    if (sb.hold_ext) begin
      valid_d = valid_q;
    end else begin
      valid_d = {valid_q[DEPTH-2:0], accept_s};
      we_d    = {we_q[DEPTH-2:0], wr_s};
      load_d  = {load_q[DEPTH-2:0], accept_s & sb.issue_is_load};
      rd_d    = {rd_q[DEPTH-2:0], sb.issue_rd};
      if (accept_s && sb.issue_use_rs && (prod_a_s != '0) && (prod_a_s < SW'(DEPTH))) begin
        fwd_a_d = prod_a_s + {{(SW-1){1'b0}}, 1'b1};
      end else begin
        fwd_a_d = '0;
      end
      if (accept_s && sb.issue_use_rt && (prod_b_s != '0) && (prod_b_s < SW'(DEPTH))) begin
        fwd_b_d = prod_b_s + {{(SW-1){1'b0}}, 1'b1};
      end else begin
        fwd_b_d = '0;
      end
    end
    cnt_d = count_ones(valid_d & we_d);
  end

  // Stage entries, forwarding selects and in-flight count.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      valid_q <= '0;
      we_q    <= '0;
      load_q  <= '0;
      rd_q    <= '0;
      fwd_a_q <= '0;
      fwd_b_q <= '0;
      cnt_q   <= '0;
    end else begin
      valid_q <= valid_d;
      we_q    <= we_d;
      load_q  <= load_d;
      rd_q    <= rd_d;
      fwd_a_q <= fwd_a_d;
      fwd_b_q <= fwd_b_d;
      cnt_q   <= cnt_d;
    end
  end

  assign sb.stall        = (sb.issue_valid & hazard_s) | sb.hold_ext;
  assign sb.fwd_a        = fwd_a_q;
  assign sb.fwd_b        = fwd_b_q;
  assign sb.inflight_cnt = cnt_q;
  assign sb.busy         = (cnt_q != '0);
endmodule

// File: tb/tb_pipe_scoreboard.sv
// Bench for pipe_scoreboard: directed hazard scenarios plus random traffic, checked
// against a list-of-instructions reference model through an expectation queue.
module tb_pipe_scoreboard;
  localparam int DEPTH = 4;
  localparam int AW = 5;
  localparam int LOAD_STAGE = 2;
  localparam int SW = $clog2(DEPTH + 1);

  logic clock;
  logic reset;
  pipe_scoreboard_if #(.AW(AW), .SW(SW)) sb_if ();

  pipe_scoreboard #(.DEPTH(DEPTH), .AW(AW), .LOAD_STAGE(LOAD_STAGE)) dut (
    .clock (clock),
    .reset (reset),
    .sb    (sb_if)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // In-flight instruction with its current stage number (1 = EX).
  typedef struct {
    logic [AW-1:0] rd;
    bit            we;
    bit            ld;
    int            age;
  } ent_t;

  typedef struct {
    bit stall;
    int fa;
    int fb;
    int cnt;
    bit busy;
  } exp_t;

  ent_t pipe_q[$];
  exp_t exp_q[$];
  int   m_fa, m_fb;
  int   n_pass, n_total;

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  function automatic int model_prod(input logic [AW-1:0] s, output bit ld);
    ld = 1'b0;
    if (s == '0) return 0;
    foreach (pipe_q[i]) begin
      if (pipe_q[i].we && pipe_q[i].rd == s) begin
        ld = pipe_q[i].ld;
        return pipe_q[i].age;
      end
    end
    return 0;
  endfunction

  function automatic int model_cnt();
    int c = 0;
    foreach (pipe_q[i]) if (pipe_q[i].we && pipe_q[i].rd != '0) c++;
    return c;
  endfunction

  function automatic void push_expect(input bit stall);
    exp_t e;
    e.stall = stall;
    e.fa    = m_fa;
    e.fb    = m_fb;
    e.cnt   = model_cnt();
    e.busy  = (e.cnt != 0);
    exp_q.push_back(e);
  endfunction

  task automatic cycle(input bit v, input logic [AW-1:0] rs, input logic [AW-1:0] rt,
                       input bit urs, input bit urt, input logic [AW-1:0] rd,
                       input bit we, input bit ld, input bit fl, input bit hd);
    int pa, pb;
    bit la, lb, haz, acc;
    ent_t n;
    @(posedge clock);
    #1;
    sb_if.issue_valid   = v;
    sb_if.issue_rs      = rs;
    sb_if.issue_rt      = rt;
    sb_if.issue_use_rs  = urs;
    sb_if.issue_use_rt  = urt;
    sb_if.issue_rd      = rd;
    sb_if.issue_we      = we;
    sb_if.issue_is_load = ld;
    sb_if.flush         = fl;
    sb_if.hold_ext      = hd;
    pa  = model_prod(rs, la);
    pb  = model_prod(rt, lb);
    haz = (urs && pa != 0 && la && pa < LOAD_STAGE) || (urt && pb != 0 && lb && pb < LOAD_STAGE);
    push_expect((v && haz) || hd);
    if (!hd) begin
      foreach (pipe_q[i]) pipe_q[i].age++;
      while (pipe_q.size() > 0 && pipe_q[$].age > DEPTH) void'(pipe_q.pop_back());
      acc = v && !haz && !fl;
      if (acc) begin
        n.rd = rd; n.we = we; n.ld = ld; n.age = 1;
        pipe_q.push_front(n);
      end
      m_fa = (acc && urs && pa != 0 && pa < DEPTH) ? pa + 1 : 0;
      m_fb = (acc && urt && pb != 0 && pb < DEPTH) ? pb + 1 : 0;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, '0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_reset(input bit chk);
    @(posedge clock);
    #1;
    reset = 1'b0;
    sb_if.issue_valid = 1'b0;
    sb_if.hold_ext    = 1'b0;
    sb_if.flush       = 1'b0;
    pipe_q.delete();
    m_fa = 0;
    m_fb = 0;
    push_expect(1'b0);
    if (chk) begin
      #2;
      check("rst_cnt", int'(sb_if.inflight_cnt), 0);
      check("rst_busy", int'(sb_if.busy), 0);
      check("rst_fwd_a", int'(sb_if.fwd_a), 0);
      check("rst_fwd_b", int'(sb_if.fwd_b), 0);
    end
    @(posedge clock);
    #1;
    push_expect(1'b0);
    #1;
    reset = 1'b1;
  endtask

  // Monitor: compare every sampled output set against the queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("stall", int'(sb_if.stall), int'(e.stall));
        check("fwd_a", int'(sb_if.fwd_a), e.fa);
        check("fwd_b", int'(sb_if.fwd_b), e.fb);
        check("inflight_cnt", int'(sb_if.inflight_cnt), e.cnt);
        check("busy", int'(sb_if.busy), int'(e.busy));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    n_pass = 0;
    n_total = 0;
    m_fa = 0;
    m_fb = 0;
    reset = 1'b0;
    sb_if.issue_valid = 1'b0;
    sb_if.issue_rs = '0;
    sb_if.issue_rt = '0;
    sb_if.issue_use_rs = 1'b0;
    sb_if.issue_use_rt = 1'b0;
    sb_if.issue_rd = '0;
    sb_if.issue_we = 1'b0;
    sb_if.issue_is_load = 1'b0;
    sb_if.flush = 1'b0;
    sb_if.hold_ext = 1'b0;
    do_reset(1'b1);

    // ALU producer forwarded from stage 1 -> fwd 2
    cycle(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 5'd3, 5'd0, 1'b1, 1'b0, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0);
    #3 check("alu_stall", int'(sb_if.stall), 0);
    idle(1);
    #3 check("alu_fwd_a", int'(sb_if.fwd_a), 2);
    idle(5);

    // Load-use: one stall cycle, then forward from stage 2 -> fwd 3
    cycle(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0);
    cycle(1'b1, 5'd5, 5'd0, 1'b1, 1'b0, 5'd10, 1'b1, 1'b0, 1'b0, 1'b0);
    #3 check("lu_stall1", int'(sb_if.stall), 1);
    cycle(1'b1, 5'd5, 5'd0, 1'b1, 1'b0, 5'd10, 1'b1, 1'b0, 1'b0, 1'b0);
    #3 check("lu_stall2", int'(sb_if.stall), 0);
    idle(1);
    #3 check("lu_fwd_a", int'(sb_if.fwd_a), 3);
    idle(5);

    // Register 0 is never pending
    cycle(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0);
    cycle(1'b1, 5'd0, 5'd0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    #3 check("r0_stall", int'(sb_if.stall), 0);
    idle(1);
    #3 check("r0_fwd_a", int'(sb_if.fwd_a), 0);
    check("r0_cnt", int'(sb_if.inflight_cnt), 0);
    idle(5);

    // Two writers of r7: youngest wins
    cycle(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 5'd0, 5'd7, 1'b0, 1'b1, 5'd12, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(1);
    #3 check("young_fwd_b", int'(sb_if.fwd_b), 2);
    idle(5);

    // Flush inserts a bubble; hold_ext freezes everything for 3 cycles
    cycle(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 5'd4, 5'd0, 1'b1, 1'b0, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 5'd6, 5'd0, 1'b1, 1'b0, 5'd8, 1'b1, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 5'd6, 5'd4, 1'b1, 1'b1, 5'd11, 1'b1, 1'b0, 1'b0, 1'b1);
      #3 check("hold_stall", int'(sb_if.stall), 1);
    end
    idle(3);

    // Reset while three entries are in flight
    for (int i = 0; i < 3; i++)
      cycle(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, AW'(i + 1), 1'b1, 1'b0, 1'b0, 1'b0);
    do_reset(1'b1);
    cycle(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0);
    #3 check("post_rst_stall", int'(sb_if.stall), 0);

    // Random traffic on a small register set so dependencies are frequent
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 99) == 0) begin
        do_reset(1'b0);
      end else begin
        cycle($urandom_range(0, 9) < 7, AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7)),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), AW'($urandom_range(0, 7)),
              $urandom_range(0, 9) < 8, $urandom_range(0, 9) < 3,
              $urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0);
      end
    end
    idle(4);
    @(posedge clock);
    #1;
    check("queue_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/pipe_scoreboard.md
PIPE_SCOREBOARD -- requirements
Module: pipe_scoreboard

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning the number of tracked stages after issue (stage 1 = EX … stage DEPTH = WB); legal range 2..8.
REQ-002 SHALL have parameter AW, default 5, meaning the register-address width.
REQ-003 SHALL have parameter LOAD_STAGE, default 2, meaning the stage whose output first carries load data; legal range 1..DEPTH-1.
REQ-004 SHALL use one clock and an asynchronous, active-low reset; ports named clock and reset.
REQ-005 clock  input  1  rising-edge clock.
REQ-006 reset  input  1  asynchronous active-low reset.
REQ-007 issue_valid  input  1  instruction in ID requests issue.
REQ-008 issue_rs, issue_rt  input  AW each  source register addresses.
REQ-009 issue_use_rs, issue_use_rt  input  1 each  source actually read.
REQ-010 issue_rd  input  AW  destination register address.
REQ-011 issue_we  input  1  instruction writes issue_rd.
REQ-012 issue_is_load  input  1  instruction is a load.
REQ-013 flush  input  1  kill the ID instruction this cycle (branch or jump taken).
REQ-014 hold_ext  input  1  external freeze of the whole pipeline (memory wait).
REQ-015 stall  output  1  hold PC and IF/ID; combinational.
REQ-016 fwd_a, fwd_b  output  SW = clog2(DEPTH+1) each  registered forward-source stage for rs/rt; 0 = register file.
REQ-017 inflight_cnt  output  SW  count of valid writing entries in stages 1..DEPTH.
REQ-018 busy  output  1  inflight_cnt != 0.

Function
REQ-019 SHALL hold one entry per stage: valid, we, is_load, rd.
REQ-020 SHALL treat register 0 as never pending: no match, no stall, forward 0.
REQ-021 SHALL take as the producer of source s the youngest (lowest k) valid stage k with we=1 and rd==s.
REQ-022 SHALL raise hazard when a used source's producer has is_load=1 and k < LOAD_STAGE.
REQ-023 SHALL drive stall = issue_valid & hazard | hold_ext.
REQ-024 When hold_ext=1, SHALL freeze all stage entries and fwd_a/fwd_b, overriding all else.
REQ-025 Otherwise SHALL shift stage k into stage k+1 each cycle; the stage DEPTH entry retires.
REQ-026 Otherwise SHALL load stage 1 from issue when issue_valid & !hazard & !flush; else SHALL load a bubble (valid=0).
REQ-027 On the stage-1 load, SHALL register fwd_a = k+1 for the rs producer at stage k when k < DEPTH.
REQ-028 SHALL register fwd_a = 0 when rs has no producer, k == DEPTH, issue_use_rs=0, or stage 1 loads a bubble; fwd_b likewise for rt.
REQ-029 SHALL register inflight_cnt with the same next-state as the stage entries.
REQ-030 On simultaneous flush and hazard, SHALL let flush win: bubble inserted, stall follows REQ-023.

Reset
REQ-031 While reset=0, SHALL clear all valid bits and hold fwd_a = fwd_b = 0, inflight_cnt = 0, busy = 0, immediately and asynchronously.
REQ-032 SHALL discard all in-flight entries when reset asserts mid-operation; the first issue after release sees no hazards.

Verification (DEPTH=4, LOAD_STAGE=2)
REQ-033 Issue add r3; next cycle issue add rs=r3 -> stall=0; next cycle fwd_a=2.
REQ-034 Issue lw r5; next cycle issue rs=r5 -> stall=1 for exactly one cycle; then fwd_a=3.
REQ-035 Issue producer rd=r0, then consumer rs=r0 -> stall=0, fwd_a=0, inflight_cnt=0.
REQ-036 Issue add r7 twice, then consumer rt=r7 -> fwd_b=2 (youngest wins).
REQ-037 issue_valid=1 with flush=1 -> stage 1 bubble, inflight_cnt unchanged; hold_ext=1 for 3 cycles -> stall=1, entries and fwd frozen.
REQ-038 Reset pulse with 3 entries in flight -> inflight_cnt=0, busy=0, fwd_a=fwd_b=0 while reset=0.
